// File: rtl/display_scan_controller_if.sv
// Bundles the measurement inputs and the scanned display outputs of display_scan_controller.
// The master drives the values to show; the slave (controller) drives the digit scan.
interface display_scan_controller_if;
  logic [7:0] frecuencia;
  logic [9:0] corriente;
  logic       mode_sel;
  logic [3:0] anode;
  logic [3:0] bcd_digit;
  logic       busy;
  logic       frame_done;

  modport master (
    output frecuencia, corriente, mode_sel,
    input  anode, bcd_digit, busy, frame_done
  );

  modport slave (
    input  frecuencia, corriente, mode_sel,
    output anode, bcd_digit, busy, frame_done
  );
endinterface

// File: rtl/display_scan_controller.sv
// Four-digit multiplexed display driver: converts the selected binary value to BCD once per
// scan frame (double dabble, one step per cycle) and scans it out with leading-zero blanking.
module display_scan_controller #(
  parameter int unsigned PRESCALE = 50000
) (
  input logic                        clk,
  input logic                        reset,
  display_scan_controller_if.slave   bus
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StConvert} state_e;

  state_e       state_q;
  logic [CntW-1:0] count_q;
  logic [1:0]   idx_q;
  logic [3:0]   anode_q;
  logic [3:0]   bcd_digit_q;
  logic         busy_q;
  logic         frame_done_q;
  logic [15:0]  disp_q;
  logic [15:0]  bcd_q;
  logic [9:0]   operand_q;
  logic [3:0]   step_q;

  logic         tick;
  logic         commit;
  logic [1:0]   idx_d;
  logic [15:0]  disp_d;
  logic [15:0]  adj;
  logic [25:0]  shifted;
  logic [3:0]   sel;
  logic         blank;

  assign tick   = (count_q == CntW'(PRESCALE - 1));
  assign commit = (state_q == StConvert) && (step_q == 4'd9);

  always_comb begin
    adj = bcd_q;
    for (int n = 0; n < 4; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
    end
    shifted = {adj, operand_q} << 1;

    idx_d  = tick ? idx_q + 2'd1 : idx_q;
    disp_d = commit ? shifted[25:10] : disp_q;

    // Digit and blanking look at next-cycle index/display so the nibble lines up with anode.
    sel   = disp_d[{idx_d, 2'b00} +: 4];
    blank = 1'b0;
    case (idx_d)
      2'd1:    blank = (disp_d[15:4] == 12'd0);
      2'd2:    blank = (disp_d[15:8] == 8'd0);
      2'd3:    blank = (disp_d[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StLoad;
      count_q      <= '0;
      idx_q        <= 2'd0;
      anode_q      <= 4'b0001;
      bcd_digit_q  <= 4'h0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      disp_q       <= 16'd0;
      bcd_q        <= 16'd0;
      operand_q    <= 10'd0;
      step_q       <= 4'd0;
    end else begin
      count_q      <= tick ? '0 : count_q + CntW'(1);
      idx_q        <= idx_d;
      anode_q      <= 4'b0001 << idx_d;
      disp_q       <= disp_d;
      bcd_digit_q  <= blank ? 4'hF : sel;
      frame_done_q <= 1'b0;

      case (state_q)
        StIdle: begin
          if (tick && (idx_q == 2'd3)) begin
            state_q <= StLoad;
            busy_q  <= 1'b1;
          end
        end
        StLoad: begin
          operand_q <= bus.mode_sel ? {2'b00, bus.frecuencia} : bus.corriente;
          bcd_q     <= 16'd0;
          step_q    <= 4'd0;
          state_q   <= StConvert;
          busy_q    <= 1'b1;
        end
        StConvert: begin
          bcd_q     <= shifted[25:10];
          operand_q <= shifted[9:0];
          step_q    <= step_q + 4'd1;
          if (step_q == 4'd9) begin
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.anode      = anode_q;
  assign bus.bcd_digit  = bcd_digit_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule
